alu_mdu_seq: RTL and testbench
==============================

// Module: alu_mdu_seq
// PURPOSE
//  Parametrised successor to the single-cycle RV32I ALU: a registered execution unit adding the RV M-extension
//  (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) with a valid/ready handshake on input and output.
//  Base ops complete in 1 cycle; MUL/DIV ops run on an iterative shift-add/restoring datapath.
//  Sits in EX between decode/regfile read and writeback; branch logic consumes its compare flags.
// PARAMETERS
//  XLEN      32  operand/result width; power of two, >= 8
//  MUL_FAST  0   1 = combinational XLEN x XLEN multiply (MUL* latency 1); 0 = iterative (latency XLEN+1)
//  SHW       $clog2(XLEN) (localparam)  shift-amount width
// PORTS
//  clk          in   1     clock, rising edge
//  rst_n        in   1     reset, asynchronous, active-low
//  in_valid     in   1     operation request
//  in_ready     out  1     unit can accept a request this cycle
//  op           in   5     operation code (encodings below)
//  a, b         in   XLEN  operands (rs1, rs2/imm)
//  out_valid    out  1     result registered and held
//  out_ready    in   1     consumer accepts result
//  result       out  XLEN  operation result
//  zero         out  1     result == 0
//  lt_signed    out  1     $signed(a) < $signed(b), from captured operands
//  lt_unsigned  out  1     a < b unsigned, from captured operands
//  busy         out  1     iterative operation in progress
// BEHAVIOUR
//  Op codes: 00 ADD 01 SUB 02 XOR 03 OR 04 AND 05 SLL 06 SRL 07 SRA 08 SLT 09 SLTU;
//   10 MUL 11 MULH 12 MULHSU 13 MULHU 14 DIV 15 DIVU 16 REM 17 REMU (hex). Any other code: result 0, latency 1.
//  Reset (async): state IDLE; out_valid, busy, result, zero, lt_* all 0; in_ready 0 while rst_n low.
//  FSM: IDLE -> (accept base op, div special case, or MUL* with MUL_FAST=1) -> DONE;
//   IDLE -> (accept MUL*/DIV* iterative) -> BUSY; BUSY -> DONE after XLEN iterations; DONE -> IDLE on out_ready.
//  Accept = in_valid && in_ready; in_ready = (state==IDLE). a, b, op captured on accept.
//  Latency (accept edge -> out_valid high): base ops 1; iterative ops XLEN+1; no throughput overlap.
//  out_valid high in DONE; result/flags stable until the out_ready cycle; out_ready while !out_valid ignored.
//  Handshake completes on out_valid && out_ready; next accept possible the following cycle.
//  Shifts use b[SHW-1:0]; SRA sign-fills from a[XLEN-1]. All arithmetic modulo 2^XLEN.
//  MUL: low XLEN of product; MULH/MULHSU/MULHU: high XLEN of signed*signed / signed*unsigned / unsigned*unsigned.
//  DIV/REM signed truncate toward zero; remainder takes dividend sign.
//  Divide by zero: DIV/DIVU = all ones, REM/REMU = a; latency 1 (no iteration).
//  Signed overflow (a = MIN, b = -1): DIV = MIN, REM = 0; latency 1.
//  zero derived from registered result; lt_* registered from captured operands for every op.
//  busy = (state==BUSY). rst_n low mid-operation aborts immediately; no partial result emitted.
// STRUCTURE
//  Package alu_mdu_pkg: op-code localparams, FSM state encoding (IDLE/BUSY/DONE), DIV-special-case helpers.
//  Sub-module muldiv_iter: iterative multiplier/restoring divider (start, op, a, b -> done, hi, lo);
//   operand sign-correction and result negation live in it; top owns FSM, handshake, base ALU, output regs.
// TESTING
//  ADD 0x7FFFFFFF+1, out_ready=1 -> out_valid 1 cycle after accept, result 0x80000000, zero 0, lt_signed 0.
//  SRA a=0x80000000 b=0x3F -> shamt 31, result 0xFFFFFFFF; SLTU a=1 b=0xFFFFFFFF -> result 1, lt_unsigned 1.
//  MULH a=0xFFFFFFFF b=0xFFFFFFFF (MUL_FAST=0) -> busy 32 cycles, out_valid at cycle 33, result 0x00000000;
//   MULHU same operands -> 0xFFFFFFFE.
//  DIV a=-7 b=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU a=5 b=0 -> 0xFFFFFFFF, latency 1; DIV 0x80000000/-1 -> 0x80000000.
//  Backpressure: out_ready low 5 cycles -> result stable, in_ready 0, new in_valid not accepted until handshake.
//  Reset mid-DIV (cycle 10 of 32) -> all outputs 0 asynchronously; after release ADD 2+3 -> 5 with no stale result.

Source files
------------

// File: rtl/alu_mdu_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : alu_mdu_pkg                                                      |
// | Brief   : Op-code map, FSM state encoding and DIV special-case helpers     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package alu_mdu_pkg;

  localparam logic [4:0] OP_ADD    = 5'h00;
  localparam logic [4:0] OP_SUB    = 5'h01;
  localparam logic [4:0] OP_XOR    = 5'h02;
  localparam logic [4:0] OP_OR     = 5'h03;
  localparam logic [4:0] OP_AND    = 5'h04;
  localparam logic [4:0] OP_SLL    = 5'h05;
  localparam logic [4:0] OP_SRL    = 5'h06;
  localparam logic [4:0] OP_SRA    = 5'h07;
  localparam logic [4:0] OP_SLT    = 5'h08;
  localparam logic [4:0] OP_SLTU   = 5'h09;
  localparam logic [4:0] OP_MUL    = 5'h10;
  localparam logic [4:0] OP_MULH   = 5'h11;
  localparam logic [4:0] OP_MULHSU = 5'h12;
  localparam logic [4:0] OP_MULHU  = 5'h13;
  localparam logic [4:0] OP_DIV    = 5'h14;
  localparam logic [4:0] OP_DIVU   = 5'h15;
  localparam logic [4:0] OP_REM    = 5'h16;
  localparam logic [4:0] OP_REMU   = 5'h17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_mul_op(input logic [4:0] op);
    return (op >= OP_MUL) && (op <= OP_MULHU);
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return (op >= OP_DIV) && (op <= OP_REMU);
  endfunction

  function automatic logic is_signed_div(input logic [4:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_rem_op(input logic [4:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  // Divide-by-zero and MIN/-1 resolve without iterating.
  function automatic logic div_special(input logic [4:0] op, input logic b_zero,
                                       input logic s_ovf);
    return is_div_op(op) && (b_zero || (is_signed_div(op) && s_ovf));
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mdu_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : alu_mdu_seq_if                                                   |
// | Brief   : Request/response handshake bundle of the ALU/MDU execution unit  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface alu_mdu_seq_if #(
  parameter int XLEN = 32
) ();

  logic            in_valid;
  logic            in_ready;
  logic [4:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            lt_signed;
  logic            lt_unsigned;
  logic            busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, zero, lt_signed, lt_unsigned, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, zero, lt_signed, lt_unsigned, busy
  );

endinterface
`default_nettype wire

// File: rtl/alu_mdu_seq_muldiv_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : muldiv_iter                                                      |
// | Brief   : XLEN-step shift-add multiplier / restoring divider with sign fix |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module muldiv_iter
  import alu_mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN);

  logic            run_q, run_d;
  logic            div_q, div_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] md_q, md_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            a_sgn, b_sgn, a_neg, b_neg, div_ge;
  logic [XLEN-1:0] a_mag, b_mag, div_diff, step_hi, step_lo;
  logic [XLEN:0]   mul_sum, div_sh;
  logic [2*XLEN-1:0] prod, prod_c;

  // Operand magnitudes; MUL low half is sign-agnostic so it runs unsigned.
  always_comb begin
    a_sgn = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_sgn = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    a_neg = a_sgn && a[XLEN-1];
    b_neg = b_sgn && b[XLEN-1];
    a_mag = a_neg ? (~a + 1'b1) : a;
    b_mag = b_neg ? (~b + 1'b1) : b;
  end

  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, md_q} : {(XLEN+1){1'b0}});
    div_sh   = {hi_q, lo_q[XLEN-1]};
    div_ge   = div_sh >= {1'b0, md_q};
    div_diff = div_sh[XLEN-1:0] - md_q;
    if (div_q) begin
      step_hi = div_ge ? div_diff : div_sh[XLEN-1:0];
      step_lo = {lo_q[XLEN-2:0], div_ge};
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  // Result is taken straight from the final step so no extra cycle is spent.
  always_comb begin
    done   = run_q && (cnt_q == CW'(XLEN - 1));
    prod   = {step_hi, step_lo};
    prod_c = qneg_q ? (~prod + 1'b1) : prod;
    if (div_q) begin
      hi = rneg_q ? (~step_hi + 1'b1) : step_hi;
      lo = qneg_q ? (~step_lo + 1'b1) : step_lo;
    end else begin
      hi = prod_c[2*XLEN-1:XLEN];
      lo = prod_c[XLEN-1:0];
    end
  end

  always_comb begin
    run_d  = run_q;
    div_d  = div_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    md_d   = md_q;
    cnt_d  = cnt_q;
    if (start) begin
      run_d  = 1'b1;
      div_d  = is_div_op(op);
      qneg_d = a_neg ^ b_neg;
      rneg_d = a_neg;
      hi_d   = '0;
      lo_d   = is_div_op(op) ? a_mag : b_mag;
      md_d   = is_div_op(op) ? b_mag : a_mag;
      cnt_d  = '0;
    end else if (run_q) begin
      hi_d  = step_hi;
      lo_d  = step_lo;
      cnt_d = cnt_q + 1'b1;
      if (done) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      div_q  <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      md_q   <= '0;
      cnt_q  <= '0;
    end else begin
      run_q  <= run_d;
      div_q  <= div_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      md_q   <= md_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_mdu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : alu_mdu_seq                                                      |
// | Brief   : Registered RV32IM-style ALU/MDU with valid/ready request/result  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module alu_mdu_seq
  import alu_mdu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_FAST = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_mdu_seq_if.slave bus
);

  localparam int   SHW  = $clog2(XLEN);
  localparam logic FAST = (MUL_FAST != 0);

  state_e          state_q, state_d;
  logic [4:0]      op_q, op_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            lt_s_q, lt_s_d;
  logic            lt_u_q, lt_u_d;

  logic            accept, lt_s_in, lt_u_in, b_zero, s_ovf, special, go_iter;
  logic            mdu_start, mdu_done;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res, special_res, quick_res, iter_res;
  logic [XLEN-1:0] mdu_hi, mdu_lo, fast_hi, fast_lo;

  assign bus.in_ready    = rst_n && (state_q == ST_IDLE);
  assign bus.out_valid   = (state_q == ST_DONE);
  assign bus.busy        = (state_q == ST_BUSY);
  assign bus.result      = result_q;
  assign bus.zero        = zero_q;
  assign bus.lt_signed   = lt_s_q;
  assign bus.lt_unsigned = lt_u_q;

  assign accept  = bus.in_valid && bus.in_ready;
  assign lt_s_in = $signed(bus.a) < $signed(bus.b);
  assign lt_u_in = bus.a < bus.b;
  assign shamt   = bus.b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (bus.op)
      OP_ADD:  alu_res = bus.a + bus.b;
      OP_SUB:  alu_res = bus.a - bus.b;
      OP_XOR:  alu_res = bus.a ^ bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_AND:  alu_res = bus.a & bus.b;
      OP_SLL:  alu_res = bus.a << shamt;
      OP_SRL:  alu_res = bus.a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(bus.a) >>> shamt);
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt_s_in};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, lt_u_in};
      default: alu_res = '0;
    endcase
  end

  // Divide by zero and MIN/-1 are answered directly from the operands.
  always_comb begin
    b_zero  = (bus.b == '0);
    s_ovf   = (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.b);
    special = div_special(bus.op, b_zero, s_ovf);
    if (b_zero) begin
      special_res = is_rem_op(bus.op) ? bus.a : '1;
    end else begin
      special_res = is_rem_op(bus.op) ? '0 : bus.a;
    end
  end

  generate
    if (MUL_FAST != 0) begin : g_mul_fast
      logic              a_sx, b_sx;
      logic [2*XLEN-1:0] ea, eb, prod;
      assign a_sx    = ((bus.op == OP_MULH) || (bus.op == OP_MULHSU)) && bus.a[XLEN-1];
      assign b_sx    = (bus.op == OP_MULH) && bus.b[XLEN-1];
      assign ea      = {{XLEN{a_sx}}, bus.a};
      assign eb      = {{XLEN{b_sx}}, bus.b};
      assign prod    = ea * eb;
      assign fast_hi = prod[2*XLEN-1:XLEN];
      assign fast_lo = prod[XLEN-1:0];
    end else begin : g_mul_iter
      assign fast_hi = '0;
      assign fast_lo = '0;
    end
  endgenerate

  always_comb begin
    if (is_mul_op(bus.op)) begin
      quick_res = (bus.op == OP_MUL) ? fast_lo : fast_hi;
    end else if (special) begin
      quick_res = special_res;
    end else begin
      quick_res = alu_res;
    end
    go_iter  = (is_div_op(bus.op) && !special) || (is_mul_op(bus.op) && !FAST);
    iter_res = ((op_q == OP_MUL) || (op_q == OP_DIV) || (op_q == OP_DIVU)) ? mdu_lo : mdu_hi;
  end

  muldiv_iter #(
    .XLEN (XLEN)
  ) u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mdu_start),
    .op    (bus.op),
    .a     (bus.a),
    .b     (bus.b),
    .done  (mdu_done),
    .hi    (mdu_hi),
    .lo    (mdu_lo)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    result_d  = result_q;
    zero_d    = zero_q;
    lt_s_d    = lt_s_q;
    lt_u_d    = lt_u_q;
    mdu_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d   = bus.op;
          lt_s_d = lt_s_in;
          lt_u_d = lt_u_in;
          if (go_iter) begin
            mdu_start = 1'b1;
            state_d   = ST_BUSY;
          end else begin
            result_d = quick_res;
            zero_d   = (quick_res == '0);
            state_d  = ST_DONE;
          end
        end
      end
      ST_BUSY: begin
        if (mdu_done) begin
          result_d = iter_res;
          zero_d   = (iter_res == '0);
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      lt_s_q   <= 1'b0;
      lt_u_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      lt_s_q   <= lt_s_d;
      lt_u_q   <= lt_u_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_mdu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_alu_mdu_seq                                                   |
// | Brief   : Directed + random bench for alu_mdu_seq against a numeric model  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_alu_mdu_seq;
  import alu_mdu_pkg::*;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  alu_mdu_seq_if #(.XLEN(XLEN)) bus ();

  alu_mdu_seq #(
    .XLEN     (XLEN),
    .MUL_FAST (0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference arithmetic on 64-bit integers.
  function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    int          sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    sh = int'(b[4:0]);
    case (op)
      OP_ADD:    return a + b;
      OP_SUB:    return a - b;
      OP_XOR:    return a ^ b;
      OP_OR:     return a | b;
      OP_AND:    return a & b;
      OP_SLL:    begin p = ua << sh;  return p[31:0]; end
      OP_SRL:    return a >> sh;
      OP_SRA:    begin p = sa >>> sh; return p[31:0]; end
      OP_SLT:    return {31'b0, sa < sb};
      OP_SLTU:   return {31'b0, ua < ub};
      OP_MUL:    begin p = sa * sb; return p[31:0];  end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * ub; return p[63:32]; end
      OP_MULHU:  begin p = ua * ub; return p[63:32]; end
      OP_DIV:    begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      OP_DIVU:   begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
      OP_REM:    begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      OP_REMU:   begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
      default:   return 32'h0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [4:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (op >= OP_MUL && op <= OP_MULHU) return XLEN + 1;
    if (op >= OP_DIV && op <= OP_REMU) begin
      if (b == 0) return 1;
      if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return XLEN + 1;
    end
    return 1;
  endfunction

  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int hold, input bit early);
    logic [31:0] exp_res;
    int          exp_lat, lat, busy_cnt;
    exp_res = ref_result(op, a, b);
    exp_lat = ref_latency(op, a, b);
    @(negedge clk);
    check_val({tag, ".in_ready"}, bus.in_ready, 1);
    bus.op        = op;
    bus.a         = a;
    bus.b         = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = early;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat      = 1;
    busy_cnt = 0;
    while (!bus.out_valid && lat < 100) begin
      busy_cnt += int'(bus.busy);
      @(posedge clk);
      #1;
      lat++;
    end
    check_val({tag, ".latency"}, lat, exp_lat);
    check_val({tag, ".busy_cycles"}, busy_cnt, exp_lat - 1);
    check_val({tag, ".result"}, bus.result, exp_res);
    check_val({tag, ".zero"}, bus.zero, exp_res == 0);
    check_val({tag, ".lt_signed"}, bus.lt_signed, $signed(a) < $signed(b));
    check_val({tag, ".lt_unsigned"}, bus.lt_unsigned, a < b);
    if (!early) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = OP_ADD;
        bus.a        = $urandom;
        bus.b        = $urandom;
        @(posedge clk);
        #1;
        check_val({tag, ".hold_result"}, bus.result, exp_res);
        check_val({tag, ".hold_valid"}, bus.out_valid, 1);
        check_val({tag, ".hold_in_ready"}, bus.in_ready, 0);
      end
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check_val({tag, ".post_valid"}, bus.out_valid, 0);
    check_val({tag, ".post_in_ready"}, bus.in_ready, 1);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    logic [4:0]  op;
    logic [31:0] a, b;
    bus.in_valid  = 1'b0;
    bus.op        = 5'h0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst.in_ready", bus.in_ready, 0);
    check_val("rst.out_valid", bus.out_valid, 0);
    check_val("rst.busy", bus.busy, 0);
    check_val("rst.result", bus.result, 0);
    check_val("rst.zero", bus.zero, 0);
    check_val("rst.lt", {bus.lt_signed, bus.lt_unsigned}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 0, 1'b1);
    run_op("sra31", OP_SRA, 32'h8000_0000, 32'h3F, 0, 1'b0);
    run_op("sltu", OP_SLTU, 32'h1, 32'hFFFF_FFFF, 0, 1'b0);
    run_op("sub_zero", OP_SUB, 32'h1234_5678, 32'h1234_5678, 0, 1'b0);
    run_op("mulh_m1", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    run_op("mulhu_m1", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    run_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFE, 32'h0000_0003, 0, 1'b1);
    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'h2, 0, 1'b0);
    run_op("rem_neg", OP_REM, 32'hFFFF_FFF9, 32'h2, 0, 1'b0);
    run_op("divu_z", OP_DIVU, 32'h5, 32'h0, 0, 1'b0);
    run_op("rem_z", OP_REM, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run_op("bp_xor", OP_XOR, 32'hA5A5_0F0F, 32'h0FF0_1234, 5, 1'b0);
    run_op("bp_divu", OP_DIVU, 32'hFFFF_FFF0, 32'h7, 5, 1'b0);
    run_op("undef", 5'h1C, 32'h1, 32'h2, 0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      op = 5'($urandom_range(0, 27));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'h0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       b = 32'($urandom_range(0, 40));
        3:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
        default: ;
      endcase
      run_op("rand", op, a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a division must drop everything at once.
    run_op("pre_rst", OP_SUB, 32'h1, 32'h5, 0, 1'b0);
    @(negedge clk);
    bus.op       = OP_DIV;
    bus.a        = 32'hFFFF_FF9C;
    bus.b        = 32'h7;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check_val("mid.busy_before", bus.busy, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("mid.out_valid", bus.out_valid, 0);
    check_val("mid.busy", bus.busy, 0);
    check_val("mid.result", bus.result, 0);
    check_val("mid.zero", bus.zero, 0);
    check_val("mid.lt", {bus.lt_signed, bus.lt_unsigned}, 0);
    check_val("mid.in_ready", bus.in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check_val("mid.no_stale_valid", bus.out_valid, 0);
    check_val("mid.no_stale_busy", bus.busy, 0);
    run_op("post_rst_add", OP_ADD, 32'h2, 32'h3, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
